uio_bus_arbiter: RTL and testbench

Shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) of the tt_um top between several internal requesters.
- Arbitration is round-robin.
- Each owner is granted the bus for either driving or sampling.
- Idle turnaround cycles are inserted whenever bus direction changes, so uio_oe never flips while a new owner drives.
- Instantiated inside the top module between the user datapath blocks and the uio ports.

---
 rtl/uio_bus_arbiter_if.sv | 40 ++++
 rtl/uio_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uio_bus_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : uio_bus_arbiter_if                                              |
// | Purpose  : Bundles the requester handshake and the uio pad signals that    |
// |            the uio bus arbiter sits between.                               |
// | Ports    : req/dir/done  per-requester request, direction, tenure end      |
// |            wdata         8 bits of drive data per requester                |
// |            gnt           one-hot registered grant                          |
// |            rdata         sampled pad data for a sampling owner             |
// |            uio_in/out/oe pad bus (oe is all-ones or all-zeros)             |
// |            busy          arbiter is in turnaround or ownership             |
// | Modports : master = requesters + pads, slave = arbiter                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface uio_bus_arbiter_if #(
   parameter int N_REQ = 2
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   dir;
   logic [N_REQ-1:0]   done;
   logic [8*N_REQ-1:0] wdata;
   logic [N_REQ-1:0]   gnt;
   logic [7:0]         rdata;
   logic [7:0]         uio_in;
   logic [7:0]         uio_out;
   logic [7:0]         uio_oe;
   logic               busy;

   modport master (
      output req, dir, done, wdata, uio_in,
      input  gnt, rdata, uio_out, uio_oe, busy
   );

   modport slave (
      input  req, dir, done, wdata, uio_in,
      output gnt, rdata, uio_out, uio_oe, busy
   );
endinterface
`default_nettype wire

// File: rtl/uio_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : uio_bus_arbiter                                                 |
// | Purpose  : Round-robin sharing of the 8-bit bidirectional uio pad bus      |
// |            between N_REQ internal requesters. Each tenure either drives    |
// |            the pads or samples them; idle turnaround cycles (uio_oe=0) are |
// |            inserted whenever the bus direction changes.                    |
// | Ports    : clk    system clock                                             |
// |            rst_n  asynchronous active-low reset                            |
// |            ena    design enable, low forces bus release                    |
// |            bus    uio_bus_arbiter_if.slave (req/dir/done/wdata in,         |
// |                   gnt/rdata/uio_out/uio_oe/busy out, uio_in in)            |
// | Params   : N_REQ (2..4), TURN_CYC (1..3), HOLD_MAX (ARB_TIMEOUT_EN only)   |
// | Option   : `define ARB_TIMEOUT_EN to revoke ownership after HOLD_MAX       |
// |            owned cycles without a normal exit.                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uio_bus_arbiter #(
   parameter int N_REQ    = 2,
   parameter int TURN_CYC = 1,
   parameter int HOLD_MAX = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   uio_bus_arbiter_if.slave  bus
);

   localparam int PW = $clog2(N_REQ);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_turn = 2'd1;
   localparam logic [1:0] c_st_own  = 2'd2;

   localparam logic [PW-1:0]    c_last_idx = PW'(N_REQ - 1);
   localparam logic [N_REQ-1:0] c_gnt_lsb  = N_REQ'(1);
   localparam logic [1:0]       c_turn_ld  = 2'(TURN_CYC - 1);

   generate
      if (N_REQ < 2 || N_REQ > 4 || TURN_CYC < 1 || TURN_CYC > 3 || HOLD_MAX < 1) begin : g_bad_param
         $error("uio_bus_arbiter: parameter out of range");
      end
   endgenerate

   logic [1:0]       r_state;
   logic [PW-1:0]    r_ptr;
   logic [PW-1:0]    r_sel;
   logic             r_dir;
   logic             r_last_dir;
   logic [1:0]       r_cnt;
   logic [N_REQ-1:0] r_gnt;
   logic             r_oe;
   logic [7:0]       r_out;
   logic [7:0]       r_rdata;

   logic [PW-1:0]    w_pick;
   logic             w_any_req;
   logic             w_pick_dir;
   logic [7:0]       w_pick_wdata;
   logic [7:0]       w_own_wdata;
   logic             w_exit;
   logic             w_timeout;

   // Round-robin search starting at r_ptr. Iterating from the far end down
   // lets the nearest requester (smallest offset) win by being written last.
   always_comb begin
      w_pick    = '0;
      w_any_req = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.req[(int'(r_ptr) + k) % N_REQ]) begin
            w_pick    = PW'((int'(r_ptr) + k) % N_REQ);
            w_any_req = 1'b1;
         end
      end
   end

   assign w_pick_dir   = bus.dir[w_pick];
   assign w_pick_wdata = bus.wdata[8*int'(w_pick) +: 8];
   assign w_own_wdata  = bus.wdata[8*int'(r_sel) +: 8];

   // Only the current owner's done/req matter; a simultaneous done and
   // req drop is naturally a single exit.
   assign w_exit = bus.done[r_sel] | ~bus.req[r_sel];

`ifdef ARB_TIMEOUT_EN
   localparam int HW = $clog2(HOLD_MAX + 1);

   logic [HW-1:0] r_hold;

   // Counts owned cycles; zero in the first cycle of every tenure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold <= '0;
      end else if (!ena || r_state != c_st_own) begin
         r_hold <= '0;
      end else begin
         r_hold <= r_hold + HW'(1);
      end
   end

   assign w_timeout = (r_hold == HW'(HOLD_MAX - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_st_idle;
         r_ptr      <= '0;
         r_sel      <= '0;
         r_dir      <= 1'b0;
         r_last_dir <= 1'b0;
         r_cnt      <= '0;
         r_gnt      <= '0;
         r_oe       <= 1'b0;
         r_out      <= '0;
         r_rdata    <= '0;
      end else if (!ena) begin
         // Forced release: pointer, last direction and sampled data persist.
         r_state <= c_st_idle;
         r_gnt   <= '0;
         r_oe    <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_any_req) begin
                  r_sel <= w_pick;
                  r_dir <= w_pick_dir;
                  if (w_pick_dir == r_last_dir) begin
                     // Pads already face the right way: grant immediately.
                     r_state <= c_st_own;
                     r_gnt   <= c_gnt_lsb << w_pick;
                     r_oe    <= w_pick_dir;
                     if (w_pick_dir) begin
                        r_out <= w_pick_wdata;
                     end
                  end else begin
                     r_state <= c_st_turn;
                     r_cnt   <= c_turn_ld;
                  end
               end
            end

            c_st_turn: begin
               if (r_cnt == 2'd0) begin
                  r_state    <= c_st_own;
                  r_last_dir <= r_dir;
                  r_gnt      <= c_gnt_lsb << r_sel;
                  r_oe       <= r_dir;
                  if (r_dir) begin
                     r_out <= w_own_wdata;
                  end
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end

            c_st_own: begin
               // Direction was latched at grant; live dir changes are ignored.
               if (r_dir) begin
                  r_out <= w_own_wdata;
               end else begin
                  r_rdata <= bus.uio_in;
               end
               if (w_exit || w_timeout) begin
                  r_state <= c_st_idle;
                  r_gnt   <= '0;
                  r_oe    <= 1'b0;
                  r_ptr   <= (r_sel == c_last_idx) ? '0 : r_sel + PW'(1);
               end
            end

            default: begin
               r_state <= c_st_idle;
               r_gnt   <= '0;
               r_oe    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.uio_oe  = {8{r_oe}};
   assign bus.uio_out = r_out;
   assign bus.rdata   = r_rdata;
   assign bus.busy    = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uio_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_uio_bus_arbiter                                              |
// | Purpose  : Self-checking bench for uio_bus_arbiter: directed scenarios     |
// |            plus randomized traffic against a tenure-level reference model. |
// | Ports    : none                                                            |
// | Option   : honours `define ARB_TIMEOUT_EN for the hold-limit scenario      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uio_bus_arbiter;

   localparam int N  = 2;
   localparam int TC = 1;
   localparam int HM = 16;
   localparam int WW = 8 * N;

   logic clk;
   logic rst_n;
   logic ena;

   int n_checks;
   int n_errors;

   uio_bus_arbiter_if #(.N_REQ(N)) bus ();

   uio_bus_arbiter #(
      .N_REQ    (N),
      .TURN_CYC (TC),
      .HOLD_MAX (HM)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model (tenure level) ----------------
   int         m_owner;   // index of current owner, -1 if none
   int         m_pend;    // requester waiting out a turnaround, -1 if none
   int         m_wait;    // turnaround cycles still to go
   int         m_ptr;
   int         m_last_dir;
   int         m_dir;
   int         m_held;
   logic [7:0] m_out;
   logic [7:0] m_rdata;

   task automatic model_reset();
      m_owner = -1; m_pend = -1; m_wait = 0; m_ptr = 0;
      m_last_dir = 0; m_dir = 0; m_held = 0; m_out = '0; m_rdata = '0;
   endtask

   function automatic int first_req(input logic [N-1:0] r, input int from);
      for (int k = 0; k < N; k++) begin
         if (r[(from + k) % N]) return (from + k) % N;
      end
      return -1;
   endfunction

   task automatic model_grant(input int p);
      m_owner    = p;
      m_pend     = -1;
      m_last_dir = m_dir;
      m_held     = 0;
      if (m_dir != 0) m_out = bus.wdata[8*p +: 8];
   endtask

   // One clock edge, using the inputs presented before that edge.
   task automatic model_step();
      int  p;
      bit  limit;
      if (!ena) begin
         m_owner = -1;
         m_pend  = -1;
      end else if (m_owner >= 0) begin
         if (m_dir != 0) m_out = bus.wdata[8*m_owner +: 8];
         else            m_rdata = bus.uio_in;
         m_held++;
`ifdef ARB_TIMEOUT_EN
         limit = (m_held == HM);
`else
         limit = 1'b0;
`endif
         if (bus.done[m_owner] || !bus.req[m_owner] || limit) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
      end else if (m_pend >= 0) begin
         m_wait--;
         if (m_wait == 0) model_grant(m_pend);
      end else begin
         p = first_req(bus.req, m_ptr);
         if (p >= 0) begin
            m_dir = int'(bus.dir[p]);
            if (m_dir == m_last_dir) model_grant(p);
            else begin
               m_pend = p;
               m_wait = TC;
            end
         end
      end
   endtask

   function automatic logic [N-1:0] m_gnt();
      return (m_owner >= 0) ? N'(1) << m_owner : '0;
   endfunction

   function automatic logic [7:0] m_oe();
      return (m_owner >= 0 && m_dir != 0) ? 8'hFF : 8'h00;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      ena         = 1'b1;
      bus.req     = '0;
      bus.dir     = '0;
      bus.done    = '0;
      bus.wdata   = '0;
      bus.uio_in  = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clear_inputs();
      bus.req = 2'b11;
      rst_n   = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.gnt !== 2'b00 || bus.uio_oe !== 8'h00 || bus.uio_out !== 8'h00 ||
          bus.rdata !== 8'h00 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_async: gnt=%b oe=%h out=%h rdata=%h busy=%b, required all zero",
                  bus.gnt, bus.uio_oe, bus.uio_out, bus.rdata, bus.busy);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.gnt !== 2'b00 || bus.uio_oe !== 8'h00 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_held: gnt=%b oe=%h busy=%b, required 00/00/0",
                  bus.gnt, bus.uio_oe, bus.busy);
      end
      model_reset();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (bus.gnt !== 2'b01) begin
         n_errors++;
         $display("FAIL reset_first_grant: gnt=%b, required 01", bus.gnt);
      end
   endtask

   task automatic test_drive_turn();
      do_reset();
      bus.req   = 2'b01;
      bus.dir   = 2'b01;
      bus.wdata = 16'h00A5;
      tick();
      n_checks++;
      if (bus.gnt !== 2'b00 || bus.uio_oe !== 8'h00 || bus.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL drive_turn: gnt=%b oe=%h busy=%b, required 00/00/1",
                  bus.gnt, bus.uio_oe, bus.busy);
      end
      tick();
      n_checks++;
      if (bus.gnt !== 2'b01 || bus.uio_oe !== 8'hFF || bus.uio_out !== 8'hA5) begin
         n_errors++;
         $display("FAIL drive_own: gnt=%b oe=%h out=%h, required 01/ff/a5",
                  bus.gnt, bus.uio_oe, bus.uio_out);
      end
      bus.done = 2'b01;
      tick();
      bus.done = 2'b00;
      bus.req  = 2'b00;
      n_checks++;
      if (bus.gnt !== 2'b00 || bus.uio_oe !== 8'h00 || bus.uio_out !== 8'hA5 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL drive_release: gnt=%b oe=%h out=%h busy=%b, required 00/00/a5/0",
                  bus.gnt, bus.uio_oe, bus.uio_out, bus.busy);
      end
   endtask

   task automatic test_sample_round_robin();
      do_reset();
      bus.req    = 2'b11;
      bus.dir    = 2'b00;
      bus.uio_in = 8'h3C;
      tick();
      tick();
      n_checks++;
      if (bus.gnt !== 2'b01 || bus.rdata !== 8'h3C || bus.uio_oe !== 8'h00) begin
         n_errors++;
         $display("FAIL sample_own0: gnt=%b rdata=%h oe=%h, required 01/3c/00",
                  bus.gnt, bus.rdata, bus.uio_oe);
      end
      bus.done = 2'b01;
      tick();
      bus.done = 2'b00;
      n_checks++;
      if (bus.gnt !== 2'b00) begin
         n_errors++;
         $display("FAIL sample_idle_gap: gnt=%b, required 00", bus.gnt);
      end
      tick();
      n_checks++;
      if (bus.gnt !== 2'b10) begin
         n_errors++;
         $display("FAIL sample_rr_next: gnt=%b, required 10", bus.gnt);
      end
      bus.uio_in = 8'hC3;
      tick();
      n_checks++;
      if (bus.rdata !== 8'hC3) begin
         n_errors++;
         $display("FAIL sample_rdata1: rdata=%h, required c3", bus.rdata);
      end
      bus.done = 2'b10;
      tick();
      bus.done = 2'b00;
      tick();
      n_checks++;
      if (bus.gnt !== 2'b01) begin
         n_errors++;
         $display("FAIL sample_wrap: gnt=%b, required 01", bus.gnt);
      end
      bus.req = 2'b00;
      tick();
   endtask

   task automatic test_dir_change();
      do_reset();
      bus.req   = 2'b11;
      bus.dir   = 2'b01;
      bus.wdata = 16'h5AA5;
      tick();
      tick();
      n_checks++;
      if (bus.gnt !== 2'b01 || bus.uio_oe !== 8'hFF) begin
         n_errors++;
         $display("FAIL dirchg_drive: gnt=%b oe=%h, required 01/ff", bus.gnt, bus.uio_oe);
      end
      bus.done = 2'b01;
      tick();
      bus.done = 2'b00;
      tick();
      n_checks++;
      if (bus.gnt !== 2'b00 || bus.uio_oe !== 8'h00 || bus.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL dirchg_turn: gnt=%b oe=%h busy=%b, required 00/00/1",
                  bus.gnt, bus.uio_oe, bus.busy);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (bus.gnt !== 2'b10 || bus.uio_oe !== 8'h00) begin
            n_errors++;
            $display("FAIL dirchg_sample c%0d: gnt=%b oe=%h, required 10/00", c, bus.gnt, bus.uio_oe);
         end
      end
      bus.req = 2'b00;
      tick();
   endtask

   task automatic test_ena_drop();
      do_reset();
      bus.req   = 2'b01;
      bus.dir   = 2'b01;
      bus.wdata = 16'h00A5;
      tick();
      tick();
      ena     = 1'b0;
      bus.req = 2'b11;
      tick();
      n_checks++;
      if (bus.gnt !== 2'b00 || bus.uio_oe !== 8'h00 || bus.busy !== 1'b0 || bus.uio_out !== 8'hA5) begin
         n_errors++;
         $display("FAIL ena_drop: gnt=%b oe=%h busy=%b out=%h, required 00/00/0/a5",
                  bus.gnt, bus.uio_oe, bus.busy, bus.uio_out);
      end
      tick();
      n_checks++;
      if (bus.gnt !== 2'b00) begin
         n_errors++;
         $display("FAIL ena_low_ignore: gnt=%b, required 00", bus.gnt);
      end
      ena = 1'b1;
      tick();
      n_checks++;
      if (bus.gnt !== 2'b01 || bus.uio_oe !== 8'hFF) begin
         n_errors++;
         $display("FAIL ena_restore: gnt=%b oe=%h, required 01/ff", bus.gnt, bus.uio_oe);
      end
      bus.req = 2'b00;
      tick();
   endtask

   task automatic test_timeout();
      int owned;
      do_reset();
      bus.req = 2'b11;
      bus.dir = 2'b00;
      tick();
`ifdef ARB_TIMEOUT_EN
      owned = 0;
      while (bus.gnt === 2'b01 && owned < 120) begin
         owned++;
         tick();
      end
      n_checks++;
      if (owned != HM) begin
         n_errors++;
         $display("FAIL timeout_len: owned %0d cycles, required %0d", owned, HM);
      end
      tick();
      n_checks++;
      if (bus.gnt !== 2'b10) begin
         n_errors++;
         $display("FAIL timeout_next: gnt=%b, required 10", bus.gnt);
      end
`else
      owned = 1;
      repeat (99) begin
         tick();
         if (bus.gnt === 2'b01) owned++;
      end
      n_checks++;
      if (bus.gnt !== 2'b01 || owned != 100) begin
         n_errors++;
         $display("FAIL hold_no_timeout: gnt=%b owned=%0d, required 01/100", bus.gnt, owned);
      end
`endif
      bus.req = 2'b00;
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         ena = ($urandom_range(19) != 0);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(5) == 0) bus.req[i] = ~bus.req[i];
            bus.done[i] = ($urandom_range(9) == 0);
         end
         bus.dir    = N'($urandom);
         bus.wdata  = WW'($urandom);
         bus.uio_in = 8'($urandom);
         tick();
         n_checks++;
         if (bus.gnt !== m_gnt() || bus.uio_oe !== m_oe()) begin
            n_errors++;
            $display("FAIL rand_gnt_oe cycle %0d: gnt=%b oe=%h, required %b/%h",
                     c, bus.gnt, bus.uio_oe, m_gnt(), m_oe());
         end
         n_checks++;
         if (bus.uio_out !== m_out || bus.rdata !== m_rdata) begin
            n_errors++;
            $display("FAIL rand_data cycle %0d: out=%h rdata=%h, required %h/%h",
                     c, bus.uio_out, bus.rdata, m_out, m_rdata);
         end
         n_checks++;
         if (bus.busy !== (m_owner >= 0 || m_pend >= 0) || $countones(bus.gnt) > 1) begin
            n_errors++;
            $display("FAIL rand_busy cycle %0d: busy=%b gnt=%b, required busy=%b and one-hot",
                     c, bus.busy, bus.gnt, (m_owner >= 0 || m_pend >= 0));
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      model_reset();
      test_reset();
      test_drive_turn();
      test_sample_round_robin();
      test_dir_change();
      test_ena_drop();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
